// File: rtl/joy_pkg.sv
// Shared definitions for the Mega Drive pad scanner.
// Holds the joystick bit positions, the raw pin positions within joy_in,
// the select-phase numbers that carry meaning, the scan FSM state enum and
// a helper that assembles one pad's published 16-bit slice.
package joy_pkg;

    // Bit positions inside one pad's 16-bit joystick slice (active-high)
    localparam int JB_RIGHT = 0;
    localparam int JB_LEFT  = 1;
    localparam int JB_DOWN  = 2;
    localparam int JB_UP    = 3;
    localparam int JB_B     = 4;
    localparam int JB_C     = 5;
    localparam int JB_A     = 6;
    localparam int JB_START = 7;
    localparam int JB_Z     = 8;
    localparam int JB_Y     = 9;
    localparam int JB_X     = 10;
    localparam int JB_MODE  = 11;

    // Raw pin positions inside joy_in = {TR,TL,P4,P3,P2,P1}
    localparam int PIN_UP    = 0;
    localparam int PIN_DOWN  = 1;
    localparam int PIN_LEFT  = 2;
    localparam int PIN_RIGHT = 3;
    localparam int PIN_TL    = 4;
    localparam int PIN_TR    = 5;

    // Select phases that carry captured information
    localparam logic [2:0] PH_DIR  = 3'd0;  // d-pad, B, C
    localparam logic [2:0] PH_ABS  = 3'd1;  // A, Start, presence
    localparam logic [2:0] PH_SIX  = 3'd5;  // six-button identification
    localparam logic [2:0] PH_EXT  = 3'd6;  // Z, Y, X, Mode
    localparam logic [2:0] PH_LAST = 3'd7;  // publication phase

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } joy_state_e;

    // Assemble a pad slice from captured (already inverted, active-high) data.
    // Absent pads publish zero; three-button pads publish zero in bits 11:8.
    function automatic logic [15:0] build_slice(
        input logic       pres,
        input logic       six,
        input logic [5:0] dir_act,
        input logic       a_act,
        input logic       start_act,
        input logic [3:0] ext_act
    );
        logic [15:0] s;
        s = 16'h0000;
        if (pres) begin
            s[JB_RIGHT] = dir_act[PIN_RIGHT];
            s[JB_LEFT]  = dir_act[PIN_LEFT];
            s[JB_DOWN]  = dir_act[PIN_DOWN];
            s[JB_UP]    = dir_act[PIN_UP];
            s[JB_B]     = dir_act[PIN_TL];
            s[JB_C]     = dir_act[PIN_TR];
            s[JB_A]     = a_act;
            s[JB_START] = start_act;
            if (six) begin
                s[JB_Z]    = ext_act[PIN_UP];
                s[JB_Y]    = ext_act[PIN_DOWN];
                s[JB_X]    = ext_act[PIN_LEFT];
                s[JB_MODE] = ext_act[PIN_RIGHT];
            end else begin
                s[11:8] = 4'h0;
            end
        end else begin
            s = 16'h0000;
        end
        return s;
    endfunction

endpackage

// File: rtl/joy_sync2.sv
// Two-flop synchroniser for asynchronous pad pins.
// Ports: clk, rst_n (async active-low), d (raw input), q (synchronised).
// Reset value is all-ones, the idle level of the active-low pad pins.
module joy_sync2 #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage resynchronisation chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {W{1'b1}};
            sync_r <= {W{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/joy_mdpad_scan.sv
// Mega Drive 3/6-button pad scanner for up to four pads on one DB9 bus.
// Ports: clk, rst_n (async active-low); joy_in raw active-low pins;
// joy_mdsel select line (TH); joy_split pad index for the splitter;
// joystick 16 bits per pad; present / six_btn per pad; frame_done strobe
// on publication of the last pad.
// Each pad is walked through eight select phases of PHASE_CYC cycles, then
// the bus rests with select high for IDLE_CYC cycles.
module joy_mdpad_scan
    import joy_pkg::*;
#(
    parameter int NPADS     = 2,
    parameter int PHASE_CYC = 480,
    parameter int IDLE_CYC  = 96000,
    localparam int SW       = (NPADS > 1) ? $clog2(NPADS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            joy_in,
    output logic                  joy_mdsel,
    output logic [SW-1:0]         joy_split,
    output logic [16*NPADS-1:0]   joystick,
    output logic [NPADS-1:0]      present,
    output logic [NPADS-1:0]      six_btn,
    output logic                  frame_done
);

    localparam int PCW = $clog2(PHASE_CYC);
    localparam int ICW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;

    logic [5:0] sync_s;

    joy_sync2 #(.W(6)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (joy_in),
        .q     (sync_s)
    );

    joy_state_e      state_r,  state_nx;
    logic [PCW-1:0]  cnt_r,    cnt_nx;
    logic [2:0]      phase_r,  phase_nx;
    logic [SW-1:0]   pad_r,    pad_nx;
    logic [ICW-1:0]  idle_r,   idle_nx;
    logic            phase_end_s;
    logic            publish_s;

    logic [5:0]      cap_dir_r;
    logic            cap_a_r;
    logic            cap_start_r;
    logic            cap_pres_r;
    logic            cap_six_r;
    logic [3:0]      cap_ext_r;
    logic [15:0]     slice_s;

    logic                  mdsel_r;
    logic [SW-1:0]         split_r;
    logic [16*NPADS-1:0]   joystick_r;
    logic [NPADS-1:0]      present_r;
    logic [NPADS-1:0]      six_btn_r;
    logic                  frame_done_r;

    // Scan/idle sequencing: cycle, phase and pad counters
    always_comb begin
        state_nx    = state_r;
        cnt_nx      = cnt_r;
        phase_nx    = phase_r;
        pad_nx      = pad_r;
        idle_nx     = idle_r;
        phase_end_s = (state_r == ST_SCAN) && (cnt_r == PCW'(PHASE_CYC - 1));
        publish_s   = phase_end_s && (phase_r == PH_LAST);
        case (state_r)
            ST_IDLE: begin
                if (idle_r == ICW'(IDLE_CYC - 1)) begin
                    state_nx = ST_SCAN;
                    idle_nx  = '0;
                    cnt_nx   = '0;
                    phase_nx = 3'd0;
                    pad_nx   = '0;
                end else begin
                    idle_nx  = idle_r + 1'b1;
                end
            end
            ST_SCAN: begin
                if (phase_end_s) begin
                    cnt_nx = '0;
                    if (phase_r == PH_LAST) begin
                        phase_nx = 3'd0;
                        if (pad_r == SW'(NPADS - 1)) begin
                            state_nx = ST_IDLE;
                            pad_nx   = '0;
                            idle_nx  = '0;
                        end else begin
                            pad_nx   = pad_r + 1'b1;
                        end
                    end else begin
                        phase_nx = phase_r + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt_r + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                phase_nx = 3'd0;
                pad_nx   = '0;
                idle_nx  = '0;
            end
        endcase
    end

    // State register; select and splitter lines are registered from the
    // next-state values so they switch exactly at phase boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            phase_r <= 3'd0;
            pad_r   <= '0;
            idle_r  <= '0;
            mdsel_r <= 1'b1;
            split_r <= '0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            phase_r <= phase_nx;
            pad_r   <= pad_nx;
            idle_r  <= idle_nx;
            mdsel_r <= (state_nx == ST_IDLE) || !phase_nx[0];
            split_r <= (state_nx == ST_IDLE) ? '0 : pad_nx;
        end
    end

    // Per-phase capture, taken only on the last cycle of each phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_dir_r   <= 6'h00;
            cap_a_r     <= 1'b0;
            cap_start_r <= 1'b0;
            cap_pres_r  <= 1'b0;
            cap_six_r   <= 1'b0;
            cap_ext_r   <= 4'h0;
        end else if (phase_end_s) begin
            case (phase_r)
                PH_DIR: cap_dir_r <= ~sync_s;
                PH_ABS: begin
                    cap_a_r     <= ~sync_s[PIN_TL];
                    cap_start_r <= ~sync_s[PIN_TR];
                    // a connected pad grounds left and right while TH is low
                    cap_pres_r  <= !sync_s[PIN_LEFT] && !sync_s[PIN_RIGHT];
                end
                PH_SIX: cap_six_r <= (sync_s[3:0] == 4'b0000);
                PH_EXT: cap_ext_r <= ~sync_s[3:0];
                default: cap_six_r <= cap_six_r;
            endcase
        end
    end

    assign slice_s = build_slice(cap_pres_r, cap_six_r, cap_dir_r,
                                 cap_a_r, cap_start_r, cap_ext_r);

    // Atomic publication of one pad's slice, presence and type
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            joystick_r   <= '0;
            present_r    <= '0;
            six_btn_r    <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= publish_s && (pad_r == SW'(NPADS - 1));
            for (int p = 0; p < NPADS; p++) begin
                if (publish_s && (pad_r == SW'(p))) begin
                    joystick_r[16*p +: 16] <= slice_s;
                    present_r[p]           <= cap_pres_r;
                    six_btn_r[p]           <= cap_pres_r && cap_six_r;
                end
            end
        end
    end

    assign joy_mdsel  = mdsel_r;
    assign joy_split  = split_r;
    assign joystick   = joystick_r;
    assign present    = present_r;
    assign six_btn    = six_btn_r;
    assign frame_done = frame_done_r;

endmodule
